asteroid_field_engine: RTL and testbench
========================================

Name: asteroid_field_engine

Overview:
- Upstream feeder of the VGA display unit. Owns the screen character memory and answers the display's screenAddr reads with a 3-bit character code.
- Internal FSM animates the field once every FRAMES_PER_SCROLL frames: scrolls asteroids down one row, generates a new top row from an LFSR, redraws the ship on the bottom row, and flags a collision.
- Frame timing comes from the display driver's vsync.

Parameters:
- COLS, 40, cells per row.
- ROWS, 30, rows; COLS*ROWS must be at most 2048.
- FRAMES_PER_SCROLL, 8, vsync frames between scroll passes.
- LFSR_SEED, 16'hACE1, nonzero reset seed.
- DENSITY, 3, new-row cell is an asteroid when lfsr[3:0] < DENSITY (0..16).

Ports:
- clk  in  1  system clock (same clock as display driver)
- reset  in  1  asynchronous, active-high
- vsync  in  1  display vsync, active-low; frame tick = registered falling edge
- screenAddr  in  11  display read address, row-major (row*COLS+col)
- character  out  3  cell code: 0 blank, 1 asteroid, 2 ship; others unused
- shipCol  in  6  requested ship column, sampled on frame tick
- collision  out  1  sticky ship/asteroid hit flag
- busy  out  1  high while FSM is not in WAIT_FRAME or HALT
- scrollCount  out  16  scroll passes survived (see Optional Feature)

Behaviour:
- Reset values: character=0, collision=0, busy=1, scrollCount=0, lfsr=LFSR_SEED, frame counter=0, latched ship column=COLS/2.
- On reset release the FSM enters CLEAR.
- Display port:
  - Independent read port; character is registered, 1-cycle latency after screenAddr.
  - screenAddr >= COLS*ROWS returns 0.
  - Same-address collision with an engine write in the same cycle is read-first: the display sees old data.
- Memory: COLS*ROWS x 3 true dual port (display read, engine read/write).
- Frame tick: vsync_q & ~vsync. The frame counter counts ticks only in WAIT_FRAME; ticks arriving while busy are dropped.
- shipCol >= COLS is clamped to COLS-1.
- FSM states:
  - CLEAR: writes 0 to address 0..COLS*ROWS-1, one per cycle, then goes to DRAW_SHIP.
  - WAIT_FRAME: on tick, samples shipCol into newCol. If frame counter = FRAMES_PER_SCROLL-1, clears the counter and goes to SCROLL; otherwise increments the counter and goes to SHIP_RD.
  - SCROLL: pipelined copy, one cell per cycle. Reads address a, descending from COLS*(ROWS-1)-1 to 0; writes that data to a+COLS on the next cycle. Takes COLS*(ROWS-1)+1 cycles. If the write destination equals bottom-row oldCol and the data is 1, sets collision. Then goes to GEN_ROW.
  - GEN_ROW: for col 0..COLS-1, writes (lfsr[3:0] < DENSITY) ? 1 : 0 to row 0. The LFSR advances once per cell (x^16+x^14+x^13+x^11 Galois). Then goes to SHIP_RD.
  - SHIP_RD: reads bottom-row newCol; data returns next cycle. If data == 1, sets collision.
  - DRAW_SHIP: writes 0 at oldCol, then 2 at newCol (2 cycles), sets oldCol = newCol, then goes to WAIT_FRAME (or HALT). When oldCol == newCol only the 2 is written.
- HALT: entered after the current pass completes when collision=1. The engine makes no writes; the display port keeps serving; collision is held. Exit only via reset.
- Reset asserted mid-pass aborts immediately; memory contents are undefined until CLEAR completes.
- collision and busy are registered outputs.

Optional Feature:
- SCORE_COUNTER_EN
- Defined: scrollCount increments by 1 at the end of each SCROLL pass in which collision stays 0. It saturates at 16'hFFFF and is cleared only by reset.
- Undefined: no counter logic; scrollCount is tied to 0.

Decomposition:
- Package asteroid_pkg holds:
  - character codes CHAR_BLANK=0, CHAR_ASTEROID=1, CHAR_SHIP=2;
  - the FSM state enum (CLEAR, WAIT_FRAME, SCROLL, GEN_ROW, SHIP_RD, DRAW_SHIP, HALT);
  - the LFSR tap constant.
- One sub-module, screen_ram_dp: generic dual-port RAM with registered read on both ports, read-first behaviour, parameterised depth and width.

Test Plan:
- Reset then release, then hold vsync high for COLS*ROWS+10 cycles -> busy falls; a sweep of all addresses reads 0 except bottom row col 20 = 2; addr 1200 reads 0.
- DENSITY=16 with 8 vsync falling edges, shipCol=5 -> after the pass, row 0 is all 1 and row 1 is unchanged (0); ship at (29,5); collision=0; scrollCount=1 when SCORE_COUNTER_EN.
- DENSITY=16 with 8x29 frames more, shipCol=5 -> when the asteroid row reaches row 29, collision=1, the FSM halts, and row contents are frozen over 20 further frames.
- shipCol=63 on tick -> clamped; ship drawn at col 39 and the old position col 20 reads 0.
- vsync falling edge during SCROLL -> the tick is ignored, the frame counter is unchanged, and the next pass occurs one frame later than with no overlap.
- Assert reset for 1 cycle mid-SCROLL -> busy=1, collision=0, scrollCount=0 immediately; CLEAR reruns and all cells except the ship read 0.

Source files
------------

// File: rtl/asteroid_field_engine_pkg.sv
// Shared definitions for the asteroid field engine: character codes, FSM states, LFSR taps.
package asteroid_pkg;

  localparam logic [2:0] CHAR_BLANK    = 3'd0;
  localparam logic [2:0] CHAR_ASTEROID = 3'd1;
  localparam logic [2:0] CHAR_SHIP     = 3'd2;

  // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [2:0] {
    CLEAR,
    WAIT_FRAME,
    SCROLL,
    GEN_ROW,
    SHIP_RD,
    DRAW_SHIP,
    HALT
  } fsm_state_t;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
  endfunction

endpackage

// File: rtl/asteroid_field_engine_if.sv
// Display-side bundle of the asteroid field engine; the engine is the slave, the display driver the master.
interface asteroid_field_engine_if;
  // Read port has no valid/ready: screenAddr is accepted every cycle and character
  // answers it exactly one clock later; vsync/shipCol are sampled, status outputs are registered.
  logic        vsync;
  logic [10:0] screenAddr;
  logic [2:0]  character;
  logic [5:0]  shipCol;
  logic        collision;
  logic        busy;
  logic [15:0] scrollCount;

  modport master (
    output vsync, screenAddr, shipCol,
    input  character, collision, busy, scrollCount
  );

  modport slave (
    input  vsync, screenAddr, shipCol,
    output character, collision, busy, scrollCount
  );
endinterface

// File: rtl/asteroid_field_engine_screen_ram_dp.sv
// Generic dual-port RAM: independent registered read ports a and b, one write on port b, read-first.
module screen_ram_dp #(
  parameter int DEPTH = 1200,
  parameter int WIDTH = 3,
  parameter int AW    = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AW-1:0]    a_addr,
  output logic [WIDTH-1:0] a_rdata,
  input  logic [AW-1:0]    b_raddr,
  output logic [WIDTH-1:0] b_rdata,
  input  logic             b_we,
  input  logic [AW-1:0]    b_waddr,
  input  logic [WIDTH-1:0] b_wdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (b_we) mem[b_waddr] <= b_wdata;
  end

  // Reads sample the array before this edge's write lands, giving old data on a same-address clash.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_rdata <= '0;
      b_rdata <= '0;
    end else begin
      a_rdata <= mem[a_addr];
      b_rdata <= mem[b_raddr];
    end
  end
endmodule

// File: rtl/asteroid_field_engine.sv
// Asteroid field engine: owns the screen character memory and animates it on vsync frame ticks.
// Build macro SCORE_COUNTER_EN adds the saturating scrollCount pass counter (tied to 0 otherwise).
module asteroid_field_engine
  import asteroid_pkg::*;
#(
  parameter int          COLS              = 40,
  parameter int          ROWS              = 30,
  parameter int          FRAMES_PER_SCROLL = 8,
  parameter logic [15:0] LFSR_SEED         = 16'hACE1,
  parameter int          DENSITY           = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  asteroid_field_engine_if.slave bus,
  output fsm_state_t             dbg_state
);
  localparam int          CELLS       = COLS * ROWS;
  localparam logic [10:0] LAST_CELL   = 11'(CELLS - 1);
  localparam logic [10:0] BOT_BASE    = 11'((ROWS - 1) * COLS);
  localparam logic [10:0] SCROLL_TOP  = 11'(CELLS - COLS - 1);
  localparam logic [10:0] SCROLL_LAST = 11'(CELLS - COLS);
  localparam logic [10:0] COL_LAST    = 11'(COLS - 1);
  localparam logic [5:0]  COL_MAX     = 6'(COLS - 1);
  localparam logic [5:0]  COL_HOME    = 6'(COLS / 2);
  localparam logic [7:0]  FRAME_LAST  = 8'(FRAMES_PER_SCROLL - 1);
  localparam logic [4:0]  DENS        = 5'(DENSITY);
  localparam logic [11:0] CELLS_12    = 12'(CELLS);

  fsm_state_t  state, state_n;
  logic [10:0] idx, idx_n;
  logic        phase, phase_n;
  logic [15:0] lfsr;
  logic [7:0]  frame_cnt;
  logic [5:0]  old_col, new_col;
  logic        collision, busy;
  logic        vsync_q, tick, oob_q;

  logic [10:0] rd_addr, waddr;
  logic        we;
  logic [2:0]  wdata, a_rdata, b_rdata;
  logic        coll_set, take_col, frame_clr, frame_inc, lfsr_adv, col_commit;

  screen_ram_dp #(.DEPTH(CELLS), .WIDTH(3), .AW(11)) u_ram (
    .clk     (clk),
    .reset   (reset),
    .a_addr  (bus.screenAddr),
    .a_rdata (a_rdata),
    .b_raddr (rd_addr),
    .b_rdata (b_rdata),
    .b_we    (we),
    .b_waddr (waddr),
    .b_wdata (wdata)
  );

  assign tick            = vsync_q & ~bus.vsync;
  assign bus.character   = oob_q ? CHAR_BLANK : a_rdata;
  assign bus.collision   = collision;
  assign bus.busy        = busy;
  assign dbg_state       = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= CLEAR;
    else       state <= state_n;
  end

  always_comb begin
    state_n    = state;
    idx_n      = idx;
    phase_n    = 1'b0;
    rd_addr    = '0;
    we         = 1'b0;
    waddr      = '0;
    wdata      = CHAR_BLANK;
    coll_set   = 1'b0;
    take_col   = 1'b0;
    frame_clr  = 1'b0;
    frame_inc  = 1'b0;
    lfsr_adv   = 1'b0;
    col_commit = 1'b0;
    case (state)
      CLEAR: begin
        we    = 1'b1;
        waddr = idx;
        idx_n = idx + 11'd1;
        if (idx == LAST_CELL) begin
          idx_n   = '0;
          state_n = DRAW_SHIP;
        end
      end
      WAIT_FRAME: begin
        if (tick) begin
          take_col = 1'b1;
          if (frame_cnt == FRAME_LAST) begin
            frame_clr = 1'b1;
            idx_n     = '0;
            state_n   = SCROLL;
          end else begin
            frame_inc = 1'b1;
            state_n   = SHIP_RD;
          end
        end
      end
      SCROLL: begin
        // Read cell idx counts down from the row above the bottom; its data is written one row lower next cycle.
        rd_addr = SCROLL_TOP - idx;
        if (idx != '0) begin
          we       = 1'b1;
          waddr    = LAST_CELL - idx + 11'd1;
          wdata    = b_rdata;
          coll_set = (waddr == BOT_BASE + {5'b0, old_col}) && (b_rdata == CHAR_ASTEROID);
        end
        idx_n = idx + 11'd1;
        if (idx == SCROLL_LAST) begin
          idx_n   = '0;
          state_n = GEN_ROW;
        end
      end
      GEN_ROW: begin
        we       = 1'b1;
        waddr    = idx;
        wdata    = ({1'b0, lfsr[3:0]} < DENS) ? CHAR_ASTEROID : CHAR_BLANK;
        lfsr_adv = 1'b1;
        idx_n    = idx + 11'd1;
        if (idx == COL_LAST) begin
          idx_n   = '0;
          state_n = SHIP_RD;
        end
      end
      SHIP_RD: begin
        rd_addr = BOT_BASE + {5'b0, new_col};
        phase_n = 1'b1;
        if (phase) begin
          phase_n  = 1'b0;
          coll_set = (b_rdata == CHAR_ASTEROID);
          state_n  = DRAW_SHIP;
        end
      end
      DRAW_SHIP: begin
        we = 1'b1;
        if (!phase && (old_col != new_col)) begin
          waddr   = BOT_BASE + {5'b0, old_col};
          wdata   = CHAR_BLANK;
          phase_n = 1'b1;
        end else begin
          waddr      = BOT_BASE + {5'b0, new_col};
          wdata      = CHAR_SHIP;
          col_commit = 1'b1;
          state_n    = collision ? HALT : WAIT_FRAME;
        end
      end
      HALT: begin
      end
      default: state_n = CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx       <= '0;
      phase     <= 1'b0;
      lfsr      <= LFSR_SEED;
      frame_cnt <= '0;
      old_col   <= COL_HOME;
      new_col   <= COL_HOME;
      collision <= 1'b0;
      busy      <= 1'b1;
      vsync_q   <= 1'b1;
      oob_q     <= 1'b0;
    end else begin
      idx     <= idx_n;
      phase   <= phase_n;
      vsync_q <= bus.vsync;
      oob_q   <= ({1'b0, bus.screenAddr} >= CELLS_12);
      busy    <= !((state_n == WAIT_FRAME) || (state_n == HALT));
      if (lfsr_adv)  lfsr      <= lfsr_step(lfsr);
      if (frame_clr) frame_cnt <= '0;
      else if (frame_inc) frame_cnt <= frame_cnt + 8'd1;
      if (take_col)   new_col <= (bus.shipCol > COL_MAX) ? COL_MAX : bus.shipCol;
      if (col_commit) old_col <= new_col;
      if (coll_set)   collision <= 1'b1;
    end
  end

`ifdef SCORE_COUNTER_EN
  logic [15:0] score;
  logic        pass_end;

  assign pass_end = (state == SCROLL) && (idx == SCROLL_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) score <= '0;
    else if (pass_end && !collision && !coll_set && (score != 16'hFFFF)) score <= score + 16'd1;
  end

  assign bus.scrollCount = score;
`else
  assign bus.scrollCount = '0;
`endif

endmodule

// File: tb/tb_asteroid_field_engine.sv
// Directed bench for asteroid_field_engine: read tables, full-screen sweeps against an image model, pass sequences.
module tb_asteroid_field_engine;
  import asteroid_pkg::*;

  localparam int COLS  = 40;
  localparam int ROWS  = 30;
  localparam int CELLS = COLS * ROWS;
  localparam int BOT   = (ROWS - 1) * COLS;
`ifdef SCORE_COUNTER_EN
  localparam bit SCORE_ON = 1'b1;
`else
  localparam bit SCORE_ON = 1'b0;
`endif

  typedef struct packed {
    logic [10:0] addr;
    logic [2:0]  exp;
  } rd_vec_t;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  fsm_state_t dbg_state;
  int         total = 0;
  int         bad   = 0;
  logic [2:0] exp_q[$];
  logic [2:0] img [CELLS];
  rd_vec_t    vec [16];
  int         n_vec = 0;
  bit         coll_model = 1'b0;

  asteroid_field_engine_if bus ();

  asteroid_field_engine #(
    .COLS(COLS), .ROWS(ROWS), .FRAMES_PER_SCROLL(8), .LFSR_SEED(16'hACE1), .DENSITY(16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic read_cell(input logic [10:0] a, output logic [2:0] v);
    @(negedge clk);
    bus.screenAddr = a;
    @(negedge clk);
    v = bus.character;
  endtask

  task automatic add_vec(input int a, input int e);
    vec[n_vec] = '{addr: 11'(a), exp: 3'(e)};
    n_vec++;
  endtask

  task automatic run_table(input string tag);
    logic [2:0] v;
    for (int i = 0; i < n_vec; i++) begin
      read_cell(vec[i].addr, v);
      check($sformatf("%s[%0d]@%0d", tag, i, vec[i].addr), 32'(v), 32'(vec[i].exp));
    end
    n_vec = 0;
  endtask

  // scoreboard: pipelined read of every cell, expected values queued from the image model
  task automatic sweep(input string tag);
    int         errs = 0;
    int         first = -1;
    logic [2:0] e;
    logic [2:0] fa = '0;
    logic [2:0] fe = '0;
    @(negedge clk);
    bus.screenAddr = '0;
    exp_q.push_back(img[0]);
    for (int i = 1; i <= CELLS; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      if (bus.character !== e) begin
        if (first < 0) begin
          first = i - 1;
          fa    = bus.character;
          fe    = e;
        end
        errs++;
      end
      if (i < CELLS) begin
        bus.screenAddr = 11'(i);
        exp_q.push_back(img[i]);
      end
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL %s: %0d cells differ, first addr %0d got %0d want %0d", tag, errs, first, fa, fe);
    end
  endtask

  task automatic wait_idle(input string tag, output int cyc);
    cyc = 0;
    while (bus.busy && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    if (bus.busy) check(tag, 32'(bus.busy), 0);
  endtask

  task automatic pulse_vsync();
    @(negedge clk);
    bus.vsync = 1'b0;
    @(negedge clk);
    bus.vsync = 1'b1;
  endtask

  task automatic frame(output int cyc);
    pulse_vsync();
    wait_idle("frame_timeout", cyc);
  endtask

  // image model of one scroll pass with a full asteroid row and the ship parked at col ship
  function automatic bit model_pass(input int ship);
    bit hit;
    for (int r = ROWS - 1; r >= 1; r--)
      for (int c = 0; c < COLS; c++) img[r*COLS+c] = img[(r-1)*COLS+c];
    for (int c = 0; c < COLS; c++) img[c] = CHAR_ASTEROID;
    hit = (img[BOT+ship] == CHAR_ASTEROID);
    img[BOT+ship] = CHAR_SHIP;
    return hit;
  endfunction

  task automatic clear_img(input int ship);
    for (int i = 0; i < CELLS; i++) img[i] = CHAR_BLANK;
    img[BOT+ship] = CHAR_SHIP;
  endtask

  // seven plain frames, then a frame that must launch a scroll pass
  task automatic run_pass(input string tag);
    int cyc;
    for (int f = 1; f <= 8; f++) begin
      frame(cyc);
      check($sformatf("%s_f%0d_scroll", tag, f), 32'(cyc > 500), 32'(f == 8));
    end
  endtask

  initial begin
    int         cyc;
    int         passes;
    logic [2:0] v;
    bus.vsync      = 1'b1;
    bus.screenAddr = '0;
    bus.shipCol    = 6'd20;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_character", 32'(bus.character), 0);
    check("rst_busy", 32'(bus.busy), 1);
    check("rst_collision", 32'(bus.collision), 0);
    check("rst_score", 32'(bus.scrollCount), 0);
    check("rst_state", 32'(dbg_state), 32'(CLEAR));
    reset = 1'b0;

    // CLEAR with vsync idle
    repeat (CELLS + 10) @(negedge clk);
    check("clear_busy", 32'(bus.busy), 0);
    check("clear_state", 32'(dbg_state), 32'(WAIT_FRAME));
    clear_img(20);
    sweep("clear_sweep");
    add_vec(0, 0); add_vec(39, 0); add_vec(BOT - 1, 0); add_vec(BOT + 19, 0);
    add_vec(BOT + 20, 2); add_vec(BOT + 21, 0); add_vec(CELLS - 1, 0);
    add_vec(1200, 0); add_vec(2047, 0);
    run_table("clear_tbl");

    // out-of-range ship column clamps to the last column
    bus.shipCol = 6'd63;
    frame(cyc);
    check("clamp_no_scroll", 32'(cyc > 500), 0);
    add_vec(BOT + 39, 2); add_vec(BOT + 20, 0); add_vec(BOT + 38, 0);
    run_table("clamp_tbl");

    // first scroll pass with the ship moved to col 5
    bus.shipCol = 6'd5;
    for (int f = 2; f <= 8; f++) begin
      frame(cyc);
      check($sformatf("pass1_f%0d_scroll", f), 32'(cyc > 500), 32'(f == 8));
    end
    clear_img(20);
    img[BOT+20] = CHAR_BLANK;
    img[BOT+5]  = CHAR_SHIP;
    coll_model  = model_pass(5);
    passes      = 1;
    sweep("pass1_sweep");
    add_vec(0, 1); add_vec(39, 1); add_vec(40, 0); add_vec(79, 0);
    add_vec(BOT + 5, 2); add_vec(BOT + 39, 0); add_vec(1200, 0);
    run_table("pass1_tbl");
    check("pass1_collision", 32'(bus.collision), 32'(coll_model));
    check("pass1_score", 32'(bus.scrollCount), SCORE_ON ? 1 : 0);

    // a tick landing during SCROLL is dropped and does not advance the frame count
    for (int f = 1; f <= 7; f++) begin
      frame(cyc);
      check($sformatf("ovl_f%0d_no_scroll", f), 32'(cyc > 500), 0);
    end
    pulse_vsync();
    repeat (100) @(negedge clk);
    check("ovl_in_scroll", 32'(dbg_state), 32'(SCROLL));
    pulse_vsync();
    wait_idle("ovl_timeout", cyc);
    coll_model |= model_pass(5);
    passes++;
    run_pass("after_ovl");
    coll_model |= model_pass(5);
    passes++;
    sweep("pass3_sweep");
    check("pass3_score", 32'(bus.scrollCount), SCORE_ON ? 3 : 0);

    // keep scrolling until the asteroid rows reach the ship
    while (passes < ROWS) begin
      run_pass($sformatf("p%0d", passes + 1));
      coll_model |= model_pass(5);
      passes++;
      check($sformatf("p%0d_collision", passes), 32'(bus.collision), 32'(coll_model));
    end
    check("halt_state", 32'(dbg_state), coll_model ? 32'(HALT) : 32'(WAIT_FRAME));
    check("halt_busy", 32'(bus.busy), 0);
    check("halt_score", 32'(bus.scrollCount), SCORE_ON ? ROWS - 1 : 0);
    sweep("halt_sweep");

    // frozen while halted
    for (int f = 0; f < 20; f++) frame(cyc);
    check("freeze_state", 32'(dbg_state), 32'(HALT));
    check("freeze_collision", 32'(bus.collision), 1);
    sweep("freeze_sweep");

    // asynchronous reset out of HALT
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst2_collision", 32'(bus.collision), 0);
    check("rst2_busy", 32'(bus.busy), 1);
    check("rst2_score", 32'(bus.scrollCount), 0);
    @(negedge clk);
    reset = 1'b0;
    wait_idle("rst2_clear_timeout", cyc);
    clear_img(20);
    read_cell(11'(BOT + 20), v);
    check("rst2_ship_home", 32'(v), 2);

    // one-cycle reset in the middle of SCROLL
    for (int f = 1; f <= 7; f++) frame(cyc);
    pulse_vsync();
    repeat (200) @(negedge clk);
    check("mid_in_scroll", 32'(dbg_state), 32'(SCROLL));
    reset = 1'b1;
    #1;
    check("mid_busy", 32'(bus.busy), 1);
    check("mid_collision", 32'(bus.collision), 0);
    check("mid_score", 32'(bus.scrollCount), 0);
    check("mid_state", 32'(dbg_state), 32'(CLEAR));
    @(negedge clk);
    reset = 1'b0;
    wait_idle("mid_clear_timeout", cyc);
    sweep("mid_clear_sweep");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
